// File: rtl/mc_control_if.sv
// Handshake/bus bundle between the instruction register, memory and the multicycle controller.
// master = controller side (drives datapath selects), slave = datapath/IR side.
interface mc_control_if #(
    parameter int ALUCTRL_W = 3
);
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic                 mem_ready;

    logic                 IRWrite;
    logic                 NextPC;
    logic                 Branch;
    logic                 PCS;
    logic                 RegW;
    logic                 MemW;
    logic                 AdrSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [1:0]           FlagW;
    logic                 illegal;

    modport master (
        input  Op, Funct, Rd, mem_ready,
        output IRWrite, NextPC, Branch, PCS, RegW, MemW, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW, illegal
    );

    modport slave (
        output Op, Funct, Rd, mem_ready,
        input  IRWrite, NextPC, Branch, PCS, RegW, MemW, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW, illegal
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle ARM controller: FETCH/DECODE/EXEC/MEM/WB sequencing plus ALU decode; MC_CONTROL_ILLEGAL_TRAP_EN selects trap-on-illegal.
// Latency: DP 4, LDR 5, STR 4, B 3 cycles with zero wait states; outputs are combinational from state and IR fields.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; each stall cycle adds one cycle.
module mc_control_fsm #(
    parameter int ALUCTRL_W = 3,
    parameter int ALU_ADD   = 0
) (
    input  logic         clk,
    input  logic         reset,
    mc_control_if.master bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXECR  = 4'd2;
    localparam logic [3:0] S_EXECI  = 4'd3;
    localparam logic [3:0] S_ALUWB  = 4'd4;
    localparam logic [3:0] S_MEMADR = 4'd5;
    localparam logic [3:0] S_MEMRD  = 4'd6;
    localparam logic [3:0] S_MEMWB  = 4'd7;
    localparam logic [3:0] S_MEMWR  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_TRAP   = 4'd10;

    localparam bit EXT_OPS = (ALUCTRL_W >= 3);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD_C = ALUCTRL_W'(ALU_ADD);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB_C = ALUCTRL_W'(ALU_ADD + 1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND_C = ALUCTRL_W'(ALU_ADD + 2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR_C = ALUCTRL_W'(ALU_ADD + 3);
    localparam logic [ALUCTRL_W-1:0] ALU_EOR_C = ALUCTRL_W'(ALU_ADD + 4);

    logic [3:0]           state;
    logic [3:0]           state_nxt;
    logic [ALUCTRL_W-1:0] alu_op;
    logic [1:0]           alu_flagw;
    logic                 funct_ok;
    logic                 no_write;
    logic                 is_addsub;
    logic                 unsupported;

    // ALU decode is computed from the held IR fields every cycle and only
    // exposed in the EXEC states; NoWrite is also needed later in ALUWB.
    always_comb begin
        alu_op    = ALU_ADD_C;
        funct_ok  = 1'b1;
        no_write  = 1'b0;
        is_addsub = 1'b0;
        case (bus.Funct[4:1])
            4'b0100: begin
                alu_op    = ALU_ADD_C;
                is_addsub = 1'b1;
            end
            4'b0010: begin
                alu_op    = ALU_SUB_C;
                is_addsub = 1'b1;
            end
            4'b0000: alu_op = ALU_AND_C;
            4'b1100: alu_op = ALU_ORR_C;
            4'b0001: begin
                if (EXT_OPS) alu_op = ALU_EOR_C;
                else         funct_ok = 1'b0;
            end
            4'b1010: begin
                if (EXT_OPS) begin
                    alu_op    = ALU_SUB_C;
                    is_addsub = 1'b1;
                    no_write  = 1'b1;
                end else begin
                    funct_ok = 1'b0;
                end
            end
            default: funct_ok = 1'b0;
        endcase
        alu_flagw = no_write ? 2'b11 : {bus.Funct[0], bus.Funct[0] & is_addsub};
    end

    assign unsupported = (bus.Op == 2'b11) || ((bus.Op == 2'b00) && !funct_ok);

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (unsupported) begin
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
                    state_nxt = S_TRAP;
`else
                    state_nxt = S_FETCH;
`endif
                end else begin
                    case (bus.Op)
                        2'b00:   state_nxt = bus.Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   state_nxt = S_MEMADR;
                        2'b10:   state_nxt = S_BRANCH;
                        default: state_nxt = S_FETCH;
                    endcase
                end
            end
            S_EXECR:  state_nxt = S_ALUWB;
            S_EXECI:  state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_MEMADR: state_nxt = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
            S_TRAP:   state_nxt = S_TRAP;
`endif
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        bus.IRWrite    = 1'b0;
        bus.NextPC     = 1'b0;
        bus.Branch     = 1'b0;
        bus.PCS        = 1'b0;
        bus.RegW       = 1'b0;
        bus.MemW       = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = ALU_ADD_C;
        bus.FlagW      = 2'b00;
        bus.illegal    = 1'b0;
        bus.ImmSrc     = bus.Op;
        bus.RegSrc     = {(bus.Op == 2'b01) && !bus.Funct[0], bus.Op == 2'b10};
        case (state)
            S_FETCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.NextPC    = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.illegal   = unsupported;
            end
            S_EXECR: begin
                bus.ALUControl = alu_op;
                bus.FlagW      = alu_flagw;
            end
            S_EXECI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_op;
                bus.FlagW      = alu_flagw;
            end
            S_ALUWB: begin
                bus.RegW = !no_write;
                bus.PCS  = (bus.Rd == 4'd15) && !no_write;
            end
            S_MEMADR: bus.ALUSrcB = 2'b01;
            S_MEMRD:  bus.AdrSrc  = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegW      = 1'b1;
                bus.PCS       = (bus.Rd == 4'd15);
            end
            S_MEMWR: begin
                bus.AdrSrc = 1'b1;
                bus.MemW   = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.Branch    = 1'b1;
                bus.PCS       = 1'b1;
            end
            S_TRAP:   bus.illegal = 1'b1;
            default:  bus.illegal = 1'b0;
        endcase
    end

endmodule
